// File: rtl/key_conditioner.sv
// Conditions raw active-low panel buttons into debounced levels and single-cycle
// press / release / long-press events for the washer control FSM.
module key_conditioner #(
   parameter int NUM_KEYS       = 4,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int HOLD_TICKS     = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } key_state_e;

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] s;

   // Synchronizer resets to all-ones so every key looks released out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_state_e    state;
      key_state_e    state_next;
      logic [DW-1:0] dcnt;
      logic [DW-1:0] dcnt_next;
      logic [HW-1:0] hcnt;
      logic [HW-1:0] hcnt_next;
      logic          long_done;
      logic          long_done_next;
      logic          level;
      logic          level_next;
      logic          press;
      logic          press_next;
      logic          rel;
      logic          rel_next;
      logic          lng;
      logic          lng_next;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state     <= RELEASED;
            dcnt      <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            lng       <= 1'b0;
         end else begin
            state     <= state_next;
            dcnt      <= dcnt_next;
            hcnt      <= hcnt_next;
            long_done <= long_done_next;
            level     <= level_next;
            press     <= press_next;
            rel       <= rel_next;
            lng       <= lng_next;
         end
      end

      // A change of s always takes priority over a coincident tick.
      always_comb begin
         state_next     = state;
         dcnt_next      = dcnt;
         hcnt_next      = hcnt;
         long_done_next = long_done;
         level_next     = level;
         press_next     = 1'b0;
         rel_next       = 1'b0;
         lng_next       = 1'b0;
         case (state)
            RELEASED: begin
               if (s[k]) begin
                  state_next = PRESS_CHK;
                  dcnt_next  = '0;
               end
            end
            PRESS_CHK: begin
               if (!s[k]) begin
                  state_next = RELEASED;
               end else if (tick) begin
                  if (dcnt == D_LAST) begin
                     state_next     = PRESSED;
                     level_next     = 1'b1;
                     press_next     = 1'b1;
                     hcnt_next      = '0;
                     long_done_next = 1'b0;
                  end else begin
                     dcnt_next = dcnt + DW'(1);
                  end
               end
            end
            PRESSED: begin
               if (!s[k]) begin
                  state_next = RELEASE_CHK;
                  dcnt_next  = '0;
               end else if (tick && !long_done) begin
                  if (hcnt == H_LAST) begin
                     lng_next       = 1'b1;
                     long_done_next = 1'b1;
                  end else begin
                     hcnt_next = hcnt + HW'(1);
                  end
               end
            end
            RELEASE_CHK: begin
               if (s[k]) begin
                  state_next = PRESSED;
               end else if (tick) begin
                  if (dcnt == D_LAST) begin
                     state_next = RELEASED;
                     level_next = 1'b0;
                     rel_next   = 1'b1;
                  end else begin
                     dcnt_next = dcnt + DW'(1);
                  end
               end
            end
            default: begin
               state_next = RELEASED;
            end
         endcase
      end

      assign key_level[k]   = level;
      assign key_press[k]   = press;
      assign key_release[k] = rel;
      assign key_long[k]    = lng;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, every cycle compared against a run-counting reference model.
module tb_key_conditioner;

   localparam int NK   = 4;
   localparam int DB   = 4;
   localparam int HOLD = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          tick;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_long;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_mode;
   int cyc        = 0;
   int tick_total = 0;
   int press_cnt[NK];
   int rel_cnt[NK];
   int long_cnt[NK];
   int press_cyc[NK];
   int press_tick[NK];
   int long_tick[NK];

   // reference model: s is raw delayed two edges; level flips after DB ticks
   // seen on edges where s has disagreed with level since the previous edge
   logic [NK-1:0] m_sync1, m_sync2, m_prev_s;
   logic [NK-1:0] m_level, m_press, m_rel, m_long, m_long_done;
   int            m_run[NK];
   int            m_hold[NK];

   always #5 clk = ~clk;

   key_conditioner #(
      .NUM_KEYS(NK),
      .DEBOUNCE_TICKS(DB),
      .HOLD_TICKS(HOLD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_long(key_long)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sync1     = '1;
      m_sync2     = '1;
      m_prev_s    = '0;
      m_level     = '0;
      m_press     = '0;
      m_rel       = '0;
      m_long      = '0;
      m_long_done = '0;
      for (int k = 0; k < NK; k++) begin
         m_run[k]  = 0;
         m_hold[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [NK-1:0] s;
      s       = ~m_sync2;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int k = 0; k < NK; k++) begin
         if (m_level[k] && s[k] && m_prev_s[k] && tick && !m_long_done[k]) begin
            m_hold[k]++;
            if (m_hold[k] == HOLD) begin
               m_long[k]      = 1'b1;
               m_long_done[k] = 1'b1;
            end
         end
         if (s[k] != m_level[k] && s[k] == m_prev_s[k]) begin
            if (tick) m_run[k]++;
            if (m_run[k] == DB) begin
               m_level[k] = s[k];
               m_run[k]   = 0;
               if (s[k]) begin
                  m_press[k]     = 1'b1;
                  m_hold[k]      = 0;
                  m_long_done[k] = 1'b0;
               end else begin
                  m_rel[k] = 1'b1;
               end
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_prev_s = s;
      m_sync2  = m_sync1;
      m_sync1  = key_n;
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin
         press_cnt[k]  = 0;
         rel_cnt[k]    = 0;
         long_cnt[k]   = 0;
         press_cyc[k]  = -1;
         press_tick[k] = -1;
         long_tick[k]  = -1;
      end
   endtask

   task automatic step();
      case (tick_mode)
         0:       tick = 1'b0;
         1:       tick = (cyc % 10 == 9);
         default: tick = ($urandom_range(2) == 0);
      endcase
      @(posedge clk);
      cyc++;
      if (reset) begin
         if (tick) tick_total++;
         model_edge();
      end
      #1;
      check("cycle", {16'd0, key_level, key_press, key_release, key_long},
            {16'd0, m_level, m_press, m_rel, m_long});
      for (int k = 0; k < NK; k++) begin
         press_cnt[k] += int'(key_press[k]);
         rel_cnt[k]   += int'(key_release[k]);
         long_cnt[k]  += int'(key_long[k]);
         if (key_press[k]) begin
            press_cyc[k]  = cyc;
            press_tick[k] = tick_total;
         end
         if (key_long[k]) long_tick[k] = tick_total;
      end
   endtask

   initial begin
      tick_mode = 1;
      tick      = 1'b0;
      key_n     = '1;
      reset     = 1'b0;
      model_reset();
      clear_counts();
      repeat (3) step();
      check("reset_outputs", {16'd0, key_level, key_press, key_release, key_long}, 32'd0);
      reset = 1'b1;

      // clean press on key 0
      clear_counts();
      key_n[0] = 1'b0;
      repeat (200) step();
      check("clean_press_cnt", press_cnt[0], 1);
      check("clean_long_cnt", long_cnt[0], 1);
      check("clean_level", {31'd0, key_level[0]}, 1);
      check("clean_others", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
      key_n[0] = 1'b1;
      repeat (80) step();
      check("clean_release_cnt", rel_cnt[0], 1);
      check("clean_level_off", {31'd0, key_level[0]}, 0);

      // bounce on key 1
      clear_counts();
      for (int i = 0; i < 100; i++) begin
         if (i % 15 == 0) key_n[1] = ~key_n[1];
         step();
      end
      check("bounce_quiet", press_cnt[1] + rel_cnt[1], 0);
      key_n[1] = 1'b0;
      repeat (100) step();
      check("bounce_press_cnt", press_cnt[1], 1);
      key_n[1] = 1'b1;
      repeat (80) step();
      check("bounce_release_cnt", rel_cnt[1], 1);

      // long press on key 2 with a short release bounce
      clear_counts();
      key_n[2] = 1'b0;
      repeat (150) step();
      check("long_cnt", long_cnt[2], 1);
      check("long_delay_ticks", long_tick[2] - press_tick[2], HOLD);
      key_n[2] = 1'b1;
      repeat (5) step();
      key_n[2] = 1'b0;
      repeat (60) step();
      check("long_no_refire", long_cnt[2], 1);
      check("long_still_level", {31'd0, key_level[2]}, 1);
      check("long_no_release", rel_cnt[2], 0);
      key_n[2] = 1'b1;
      repeat (80) step();
      check("long_release_cnt", rel_cnt[2], 1);

      // asynchronous reset while key 0 is pressed
      clear_counts();
      key_n[0] = 1'b0;
      repeat (60) step();
      check("rst_pre_level", {31'd0, key_level[0]}, 1);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_async_clear", {16'd0, key_level, key_press, key_release, key_long}, 32'd0);
      repeat (3) step();
      reset = 1'b1;
      clear_counts();
      repeat (70) step();
      check("rst_repress_cnt", press_cnt[0], 1);
      check("rst_no_release", rel_cnt[0], 0);
      key_n[0] = 1'b1;
      repeat (80) step();

      // simultaneous presses on keys 0 and 3
      clear_counts();
      key_n[0] = 1'b0;
      key_n[3] = 1'b0;
      repeat (70) step();
      check("simul_press0", press_cnt[0], 1);
      check("simul_press3", press_cnt[3], 1);
      check("simul_coincident", press_cyc[0], press_cyc[3]);
      key_n[3] = 1'b1;
      repeat (70) step();
      check("simul_release3", rel_cnt[3], 1);
      check("simul_release0", rel_cnt[0], 0);
      check("simul_level0", {31'd0, key_level[0]}, 1);
      key_n[0] = 1'b1;
      repeat (80) step();

      // no tick: key held but never qualifies
      clear_counts();
      tick_mode = 0;
      key_n[0]  = 1'b0;
      repeat (1000) step();
      check("notick_level", {31'd0, key_level[0]}, 0);
      check("notick_pulses", press_cnt[0] + rel_cnt[0] + long_cnt[0], 0);
      tick_mode = 1;
      repeat (70) step();
      check("notick_then_press", press_cnt[0], 1);
      key_n[0] = 1'b1;
      repeat (80) step();

      // random key activity and random tick spacing
      tick_mode = 2;
      repeat (3000) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(19) == 0) key_n[k] = ~key_n[k];
         end
         step();
      end
      key_n = '1;
      repeat (100) step();
      check("final_idle", {28'd0, key_level}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
